alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the single-cycle ALU for the pipelined CPU's execute stage. It executes the RV32I integer ALU operations with a registered result. It also executes the RV32M multiply/divide operations as iterative multi-cycle operations. The execute stage stalls on `in_ready`/`out_valid`, so the result is not read in the same cycle as the operands.

## Interface
- `XLEN`, 32: operand/result width; power of two, ≥8.
- `SHW`, $clog2(XLEN): shift-amount width (derived, not overridden).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  unit accepts an operation this cycle.
- `op`  in  5  operation code:
  - `op[4]=0`: base op, `op[3:0]={funct7[5],funct3}`.
  - `op[4]=1`: M-extension op, `op[2:0]=funct3`, `op[3]` ignored.
- `a`  in  XLEN  operand A (rs1).
- `b`  in  XLEN  operand B (rs2/imm).
- `out_valid`  out  1  `res`/`zero` valid.
- `out_ready`  in  1  consumer takes result.
- `res`  out  XLEN  result.
- `zero`  out  1  `res == 0`, registered with `res`.

## Operation
- Accept occurs when `in_valid & in_ready`. `op`, `a` and `b` are captured on accept; inputs are don't-care afterwards.
- States:
  - IDLE → DONE on accept of a base op, or of a div/rem fast-path case.
  - IDLE → MUL on accept of MUL/MULH/MULHSU/MULHU (funct3 0–3).
  - IDLE → DIV on accept of DIV/DIVU/REM/REMU (funct3 4–7).
  - MUL/DIV → DONE after exactly XLEN iteration cycles.
  - DONE → IDLE on `out_ready`, unless a new op is accepted in that same cycle. In that case go directly to that op's next state.
- `in_ready = (state==IDLE) | (state==DONE & out_ready)`.
- `out_valid = (state==DONE)`. `res`/`zero` are held stable while `out_valid & ~out_ready`.
- Base ops, with `sh = b[SHW-1:0]`:
  - 0000 add
  - 1000 sub
  - 0001 sll
  - 0010 slt (signed)
  - 0011 sltu
  - 0100 xor
  - 0101 srl
  - 1101 sra
  - 0110 or
  - 0111 and
  - Any other base code gives `res=0`, `zero=1`.
- Multiply: radix-2 shift-add over a 2·XLEN product, one bit per cycle. Operands are sign- or zero-extended to XLEN+1 bits per op.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring divide on magnitudes, one quotient bit per cycle. Signs are applied at completion.
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
- Div/rem fast path, one cycle, with no DIV state:
  - `b==0`: quotient all-ones, remainder `a`.
  - Signed overflow (`a` = most-negative, `b` = all-ones, DIV/REM only): quotient `a`, remainder 0.

## Timing
- Reset values: state IDLE, `out_valid=0`, `in_ready=1`, `res=0`, `zero=0`; iteration counter 0.
- Latency, from accept edge to `out_valid` high:
  - Base ops and div fast path: 1 cycle.
  - MUL/DIV: XLEN+1 cycles (32-bit: 33).
- Throughput with `out_ready` held high:
  - Base ops: one per cycle (back-to-back through DONE).
  - MUL/DIV: one per XLEN+1 cycles.
- `in_valid` while busy (MUL/DIV, or DONE without `out_ready`) is not accepted. The producer holds it.
- `rst` in any state: next cycle is IDLE with `out_valid=0`. Any in-flight result is discarded. An accept in the reset cycle is ignored.
- `out_ready` asserted while not DONE: no effect.

## Configuration
- `ALU_SEQ_M_EN`:
  - Defined: MUL and DIV states, datapaths and counter are compiled in, as above.
  - Undefined: no MUL/DIV hardware. Any `op[4]=1` goes IDLE→DONE in 1 cycle with `res=0`, `zero=1`. Base-op behaviour and timing are unchanged.

## Test plan
- Reset then base ops, `out_ready=1`, back-to-back add 5+7, sub 3-5, sra 0x80000000>>>4 → `res` = 12, 0xFFFFFFFE, 0xF8000000 on consecutive cycles, starting 1 cycle after the first accept.
- MULH −2×3 and MULHU 0xFFFFFFFF×0xFFFFFFFF → `res` 0xFFFFFFFF and 0xFFFFFFFE. `out_valid` rises exactly 33 cycles after each accept; `in_ready=0` throughout.
- DIV −7/2, REM −7/2, DIVU 7/0, DIV 0x80000000/−1 → −3, −1, 0xFFFFFFFF (1-cycle latency), 0x80000000 (1-cycle latency).
- Backpressure: `out_ready=0` for 5 cycles after an add result → `res`/`zero`/`out_valid` stable, `in_ready=0`. A new op is accepted in the cycle `out_ready` rises.
- Reset asserted at iteration 10 of a DIV → next cycle IDLE, `out_valid=0`, `res=0`. The following add 1+1 returns 2 after 1 cycle.
- Built without `ALU_SEQ_M_EN`: MUL 3×4 → `res=0`, `zero=1`, latency 1. Base op sltu 1<2 → 1.

Source files
------------

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Brief    : Operand/result handshake bundle for the sequential ALU.
// Revision : 1.0
// ============================================================================
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked RV32I ALU with registered result; iterative RV32M
//            mul/div compiled in when ALU_SEQ_M_EN is defined.
// Revision : 1.0
// ============================================================================
module alu_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic            in_ready, accept, ld_res;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] base_res;

  assign sh       = bus.b[SHW-1:0];
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    base_res = '0;
    case (bus.op[3:0])
      4'b0000: base_res = bus.a + bus.b;
      4'b1000: base_res = bus.a - bus.b;
      4'b0001: base_res = bus.a << sh;
      4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      4'b0011: base_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      4'b0100: base_res = bus.a ^ bus.b;
      4'b0101: base_res = bus.a >> sh;
      4'b1101: base_res = $signed(bus.a) >>> sh;
      4'b0110: base_res = bus.a | bus.b;
      4'b0111: base_res = bus.a & bus.b;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_SEQ_M_EN
  localparam logic [SHW-1:0] ITER_LAST = '1;

  // acc holds {high, multiplier} for MUL and {remainder, quotient} for DIV
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shf, div_dif;
  logic [2*XLEN-1:0] mul_step, mul_fin, div_step;
  logic [XLEN-1:0]   div_val, div_fin;

  always_comb begin
    is_div   = bus.op[2];
    a_sgn    = is_div ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
    b_sgn    = is_div ? ~bus.op[0] : ~bus.op[1];
    a_neg    = a_sgn & bus.a[XLEN-1];
    b_neg    = b_sgn & bus.b[XLEN-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    mul_fin  = neg_q ? -mul_step : mul_step;
    div_shf  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_dif  = div_shf - {1'b0, opb_q};
    div_step = div_dif[XLEN] ? {div_shf[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                             : {div_dif[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    div_val  = f3_q[1] ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];
    div_fin  = neg_q ? -div_val : div_val;
  end
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ld_res  = 1'b0;
`ifdef ALU_SEQ_M_EN
    acc_d   = acc_q;
    opb_d   = opb_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
`endif
    if (accept) begin
      state_d = S_DONE;
      ld_res  = 1'b1;
      if (!bus.op[4]) begin
        res_d = base_res;
      end else begin
`ifdef ALU_SEQ_M_EN
        f3_d  = bus.op[2:0];
        opb_d = b_mag;
        acc_d = {{XLEN{1'b0}}, a_mag};
        cnt_d = '0;
        neg_d = (is_div & bus.op[1]) ? a_neg : (a_neg ^ b_neg);
        if (!is_div) begin
          state_d = S_MUL;
          ld_res  = 1'b0;
        end else if (bus.b == '0) begin
          res_d = bus.op[1] ? bus.a : '1;
        end else if (~bus.op[0] & (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.b)) begin
          res_d = bus.op[1] ? '0 : bus.a;
        end else begin
          state_d = S_DIV;
          ld_res  = 1'b0;
        end
`else
        res_d = '0;
`endif
      end
    end else begin
      case (state_q)
        S_DONE: if (bus.out_ready) state_d = S_IDLE;
`ifdef ALU_SEQ_M_EN
        S_MUL: begin
          acc_d = mul_step;
          cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
          if (cnt_q == ITER_LAST) begin
            state_d = S_DONE;
            ld_res  = 1'b1;
            res_d   = (f3_q[1:0] == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
          end
        end
        S_DIV: begin
          acc_d = div_step;
          cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
          if (cnt_q == ITER_LAST) begin
            state_d = S_DONE;
            ld_res  = 1'b1;
            res_d   = div_fin;
          end
        end
`endif
        default: ;
      endcase
    end
    zero_d = ld_res ? ~|res_d : zero_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
`ifdef ALU_SEQ_M_EN
      acc_q   <= '0;
      opb_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
`ifdef ALU_SEQ_M_EN
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.res       = res_q;
  assign bus.zero      = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed-vector scoreboard bench for alu_seq.
// Revision : 1.0
// ============================================================================
module tb_alu_seq;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    int          due;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  exp_t  exp_q[$];
  string name_q[$];
  exp_t  e;
  string en;
  logic  pending = 1'b0;
  int    first_cyc = 0;
  int    w;
  logic  bad;
  logic [31:0] hold_res;
  logic        hold_zero;

  alu_seq_if #(.XLEN(XLEN)) bus ();
  alu_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: samples mid-cycle, pops on each completed transfer
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      pending = 1'b0;
    end else if (bus.out_valid === 1'b1) begin
      if (!pending) begin
        pending   = 1'b1;
        first_cyc = cyc;
      end
      if (bus.out_ready === 1'b1) begin
        pending = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got 0x%08h expected no result", bus.res);
        end else begin
          e  = exp_q.pop_front();
          en = name_q.pop_front();
          chk({en, "_res"}, bus.res, e.res);
          chk({en, "_zero"}, {31'b0, bus.zero}, {31'b0, e.zero});
          chk({en, "_latency"}, first_cyc, e.due);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input int lat,
                       input bit push, output int waited);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    waited = 0;
    #1;
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout: got in_ready=0 expected in_ready=1", name);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (push) begin
      exp_q.push_back('{res: er, zero: (er == 32'd0), due: cyc + lat - 1});
      name_q.push_back(name);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

`ifdef ALU_SEQ_M_EN
  task automatic busy_check(input string name);
    bad = 1'b0;
    for (int k = 0; k < XLEN; k++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad = 1'b1;
      if (k != XLEN - 1) cycle();
    end
    chk({name, "_busy"}, {31'b0, bad}, 32'd0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_res", bus.res, 32'd0);
    chk("rst_zero", {31'b0, bus.zero}, 32'd0);

    // Base ops back-to-back, one result per cycle
    issue("add",  5'b00000, 32'd5,          32'd7,          32'd12,         1, 1, w);
    issue("sub",  5'b01000, 32'd3,          32'd5,          32'hFFFFFFFE,   1, 1, w);
    issue("sra",  5'b01101, 32'h80000000,   32'd4,          32'hF8000000,   1, 1, w);
    issue("sll",  5'b00001, 32'd1,          32'd31,         32'h80000000,   1, 1, w);
    issue("slt",  5'b00010, 32'hFFFFFFFF,   32'd2,          32'd1,          1, 1, w);
    issue("sltu", 5'b00011, 32'hFFFFFFFF,   32'd2,          32'd0,          1, 1, w);
    issue("xor",  5'b00100, 32'h0000F0F0,   32'h0000FF00,   32'h00000FF0,   1, 1, w);
    issue("srl",  5'b00101, 32'h80000000,   32'd36,         32'h08000000,   1, 1, w);
    issue("or",   5'b00110, 32'h000000F0,   32'h0000000F,   32'h000000FF,   1, 1, w);
    issue("and",  5'b00111, 32'h000000F0,   32'h0000000F,   32'd0,          1, 1, w);
    issue("bad",  5'b01001, 32'd9,          32'd9,          32'd0,          1, 1, w);
    drain();

`ifdef ALU_SEQ_M_EN
    issue("mulh", 5'b10001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33, 1, w);
    busy_check("mulh");
    issue("mulhu", 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1, w);
    busy_check("mulhu");
    issue("mul", 5'b10000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1, w);
    issue("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, 1, w);
    issue("div", 5'b10100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1, w);
    issue("rem", 5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1, w);
    issue("divu_by0", 5'b10101, 32'd7, 32'd0, 32'hFFFFFFFF, 1, 1, w);
    issue("div_ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, w);
    issue("remu_by0", 5'b10111, 32'd7, 32'd0, 32'd7, 1, 1, w);
    issue("rem_ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1, w);
    issue("divu", 5'b10101, 32'd100, 32'd7, 32'd14, 33, 1, w);
    drain();
`else
    issue("mul_noM", 5'b10000, 32'd3, 32'd4, 32'd0, 1, 1, w);
    issue("divu_noM", 5'b10101, 32'd7, 32'd2, 32'd0, 1, 1, w);
    issue("sltu2", 5'b00011, 32'd1, 32'd2, 32'd1, 1, 1, w);
    drain();
`endif

    // Backpressure: result must hold while out_ready is low
    bus.out_ready = 1'b0;
    issue("bp_add", 5'b00000, 32'd2, 32'd3, 32'd5, 1, 1, w);
    chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
    hold_res = bus.res;
    hold_zero = bus.zero;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.res !== hold_res || bus.zero !== hold_zero) bad = 1'b1;
    end
    chk("bp_stable", {31'b0, bad}, 32'd0);
    bus.out_ready = 1'b1;
    issue("bp_sub", 5'b01000, 32'd10, 32'd4, 32'd6, 1, 1, w);
    chk("bp_accept_same_cycle", w, 32'd0);
    drain();

    // Reset with work in flight discards it
`ifdef ALU_SEQ_M_EN
    issue("rst_div", 5'b10101, 32'd1000, 32'd3, 32'd333, 33, 0, w);
    repeat (10) cycle();
`else
    bus.out_ready = 1'b0;
    issue("rst_add", 5'b00000, 32'd9, 32'd9, 32'd18, 1, 0, w);
    repeat (3) cycle();
`endif
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("rst2_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst2_res", bus.res, 32'd0);
    chk("rst2_in_ready", {31'b0, bus.in_ready}, 32'd1);
    issue("add_after_rst", 5'b00000, 32'd1, 32'd1, 32'd2, 1, 1, w);
    drain();
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
